// File: rtl/tag_issue_ctrl_if.sv
// Request, allocator and completion signals of the tag issue controller.
interface tag_issue_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int TW      = 4
);
  logic                    cfg_valid;
  logic [7:0]              cfg_kernel_size;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*TW-1:0]   req_tag;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    flush_tag;
  logic [TW-1:0]           tag_in;
  logic [7:0]              kernel_size;
  logic                    tag_busy;
  logic                    done_valid;
  logic [TW-1:0]           done_tag;
  logic                    drop_err;
  logic                    ctrl_busy;

  // Requesters, allocator and completion consumer.
  modport master (
    output cfg_valid, cfg_kernel_size, req_valid, req_tag, tag_busy,
    input  req_ready, flush_tag, tag_in, kernel_size, done_valid, done_tag,
           drop_err, ctrl_busy
  );

  // The controller itself.
  modport slave (
    input  cfg_valid, cfg_kernel_size, req_valid, req_tag, tag_busy,
    output req_ready, flush_tag, tag_in, kernel_size, done_valid, done_tag,
           drop_err, ctrl_busy
  );
endinterface

// File: rtl/tag_issue_ctrl.sv
// Round-robin tag-load scheduler in front of the column tag allocator.
// Grants one request at a time, flushes the tag with bounded retry on
// allocator rejects, then waits for the tag to settle across the columns.
module tag_issue_ctrl #(
  parameter int NUM_COL   = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rstn,
  tag_issue_ctrl_if.slave  bus
);
  localparam int TW = $clog2(NUM_COL) + 1;
  localparam int PW = $clog2(NUM_REQ);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned NR = NUM_REQ;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
  localparam logic [7:0]    NC8   = 8'(NUM_COL);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tag_q;
  logic [TW-1:0]   tag_in_q;
  logic [7:0]      ks_q;
  logic [7:0]      ks_eff;
  logic [PW-1:0]   ptr_q;
  logic [RW-1:0]   retry_q;
  logic [7:0]      cnt_q;
  logic            drop_q;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic [TW-1:0]      grant_tag;
  logic               found;
  logic               take;
  logic               flush;
  logic               done;
  int unsigned        cand;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = (int'(ptr_q) + i) % NR;
      if (!found && bus.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = PW'(cand);
      end
    end
    take = (state_q == IDLE) && !bus.cfg_valid && found;
    if (take) grant[grant_idx] = 1'b1;
    grant_tag = bus.req_tag[int'(grant_idx)*TW +: TW];
  end

  // Clamp the configured kernel size to 1..NUM_COL.
  always_comb begin
    ks_eff = ks_q;
    if (ks_q == '0)      ks_eff = 8'd1;
    else if (ks_q > NC8) ks_eff = NC8;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:   if (take && grant_tag != '0) state_d = ISSUE;
      ISSUE: begin
        flush   = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (!bus.tag_busy)      state_d = SETTLE;
        else if (retry_q < MAX_R) state_d = ISSUE;
        else                    state_d = IDLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: config, latched tag, pointer, retry/settle counters, drop pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q    <= '0;
      tag_in_q <= '0;
      ks_q     <= 8'd1;
      ptr_q    <= PW'(NUM_REQ - 1);
      retry_q  <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_valid) begin
            ks_q <= bus.cfg_kernel_size;
          end else if (take) begin
            tag_q   <= grant_tag;
            ptr_q   <= grant_idx;
            retry_q <= '0;
            // A zero tag is consumed and reported as dropped without a flush,
            // so tag_in keeps showing the last tag actually issued.
            if (grant_tag == '0) drop_q   <= 1'b1;
            else                 tag_in_q <= grant_tag;
          end
        end
        ISSUE: retry_q <= retry_q + 1'b1;
        CHECK: begin
          if (!bus.tag_busy)         cnt_q  <= ks_eff - 8'd1;
          else if (retry_q >= MAX_R) drop_q <= 1'b1;
        end
        SETTLE: if (cnt_q != '0) cnt_q <= cnt_q - 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = grant;
  assign bus.flush_tag   = flush;
  assign bus.tag_in      = tag_in_q;
  assign bus.kernel_size = ks_q;
  assign bus.done_valid  = done;
  assign bus.done_tag    = (done || drop_q) ? tag_q : '0;
  assign bus.drop_err    = drop_q;
  assign bus.ctrl_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_tag_issue_ctrl.sv
// Scoreboard bench for tag_issue_ctrl: directed transfers push their expected
// grant/flush/done/drop events with cycle stamps; a monitor pops and compares.
module tb_tag_issue_ctrl;
  localparam int NREQ = 4;
  localparam int TW   = 4;
  localparam int MAXR = 3;

  typedef struct {
    int kind;   // 0 grant mask, 1 flush tag, 2 done tag, 3 drop tag
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ksm = 1;
  int   rej_left = 0;
  bit   flush_seen = 1'b0;
  bit   alloc_fl;
  ev_t  exp_q[$];

  tag_issue_ctrl_if #(.NUM_REQ(NREQ), .TW(TW)) bus();

  tag_issue_ctrl #(.NUM_COL(8), .NUM_REQ(NREQ), .MAX_RETRY(MAXR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Allocator model: answers busy in the cycle after a flush.
  always @(posedge clk) begin
    alloc_fl = flush_seen;
    #1;
    if (alloc_fl && rej_left > 0) begin
      bus.tag_busy = 1'b1;
      rej_left--;
    end else begin
      bus.tag_busy = 1'b0;
    end
  end

  function automatic void observe(input int kind, input int val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endfunction

  // Monitor: collect DUT events once per cycle, away from the rising edge.
  always @(negedge clk) begin
    flush_seen = bus.flush_tag;
    if (rstn) begin
      if (|(bus.req_valid & bus.req_ready)) observe(0, int'(bus.req_ready));
      if (bus.flush_tag)  observe(1, int'(bus.tag_in));
      if (bus.done_valid) observe(2, int'(bus.done_tag));
      if (bus.drop_err)   observe(3, int'(bus.done_tag));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    int n = 0;
    while (cyc < c && n < 2000) begin
      tick();
      n++;
    end
    if (cyc < c) check("wait_timeout", cyc, c);
  endtask

  function automatic void push(input int kind, input int val, input int c);
    exp_q.push_back('{kind, val, c});
  endfunction

  // Expected events for a request granted in cycle t.
  task automatic sched(input int t, input int idx, input int tag, input int rej, output int last);
    push(0, 1 << idx, t);
    if (tag == 0) begin
      push(3, 0, t + 1);
      last = t + 1;
    end else if (rej >= MAXR) begin
      for (int j = 0; j < MAXR; j++) push(1, tag, t + 1 + 2*j);
      push(3, tag, t + 1 + 2*MAXR);
      last = t + 1 + 2*MAXR;
    end else begin
      for (int j = 0; j <= rej; j++) push(1, tag, t + 1 + 2*j);
      push(2, tag, t + 2 + 2*rej + ksm);
      last = t + 2 + 2*rej + ksm;
    end
  endtask

  task automatic set_tag(input int idx, input int tag);
    bus.req_tag[idx*TW +: TW] = TW'(tag);
  endtask

  task automatic xfer(input int idx, input int tag, input int rej);
    int last;
    set_tag(idx, tag);
    bus.req_valid[idx] = 1'b1;
    rej_left = rej;
    sched(cyc, idx, tag, rej, last);
    tick();
    bus.req_valid[idx] = 1'b0;
    wait_to(last + 1);
    rej_left = 0;
  endtask

  task automatic cfg(input int ks);
    bus.cfg_valid = 1'b1;
    bus.cfg_kernel_size = 8'(ks);
    tick();
    bus.cfg_valid = 1'b0;
    ksm = (ks == 0) ? 1 : (ks > 8) ? 8 : ks;
  endtask

  initial begin
    int t, l1, l2;
    bus.cfg_valid = 1'b0;
    bus.cfg_kernel_size = '0;
    bus.req_valid = '0;
    bus.req_tag = '0;
    bus.tag_busy = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_flush", int'(bus.flush_tag), 0);
    check("rst_tag_in", int'(bus.tag_in), 0);
    check("rst_kernel_size", int'(bus.kernel_size), 1);
    check("rst_done", int'(bus.done_valid), 0);
    check("rst_drop", int'(bus.drop_err), 0);
    check("rst_busy", int'(bus.ctrl_busy), 0);
    tick();

    // Basic transfer with kernel size 3.
    cfg(3);
    check("cfg_ks3", int'(bus.kernel_size), 3);
    xfer(0, 5, 0);

    // Fresh reset so the round-robin pointer starts at req0.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    ksm = 1;
    tick();

    // All four held: grants 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) set_tag(i, i + 1);
    bus.req_valid = 4'hF;
    t = cyc;
    for (int j = 0; j < 5; j++) sched(t + 4*j, j % NREQ, (j % NREQ) + 1, 0, l1);
    wait_to(t + 17);
    bus.req_valid = '0;
    wait_to(l1 + 1);

    // After a grant to req2, req3 beats req1.
    xfer(2, 6, 0);
    bus.req_valid = 4'b1010;
    t = cyc;
    sched(t, 3, 4, 0, l1);
    sched(t + 4, 1, 2, 0, l2);
    tick();
    bus.req_valid[3] = 1'b0;
    wait_to(t + 5);
    bus.req_valid[1] = 1'b0;
    wait_to(l2 + 1);

    // Two rejects then accept; then stuck busy drops; next request still served.
    xfer(0, 9, 2);
    xfer(1, 7, 99);
    xfer(2, 3, 0);

    // Kernel size clamping.
    cfg(0);
    check("cfg_ks0", int'(bus.kernel_size), 0);
    xfer(3, 12, 0);
    cfg(20);
    check("cfg_ks20", int'(bus.kernel_size), 20);
    xfer(0, 15, 0);

    // cfg during SETTLE is ignored.
    cfg(2);
    set_tag(1, 4);
    bus.req_valid[1] = 1'b1;
    t = cyc;
    sched(t, 1, 4, 0, l1);
    tick();
    bus.req_valid[1] = 1'b0;
    wait_to(t + 3);
    bus.cfg_valid = 1'b1;
    bus.cfg_kernel_size = 8'd7;
    tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("cfg_in_settle_ks", int'(bus.kernel_size), 2);
    check("settle_busy", int'(bus.ctrl_busy), 1);
    wait_to(l1 + 1);

    // Zero tag is dropped without a flush.
    xfer(2, 0, 0);

    // Reset during SETTLE: no done, outputs cleared, req0 wins afterwards.
    cfg(5);
    set_tag(2, 11);
    bus.req_valid[2] = 1'b1;
    t = cyc;
    push(0, 4, t);
    push(1, 11, t + 1);
    tick();
    bus.req_valid[2] = 1'b0;
    wait_to(t + 4);
    rstn = 1'b0;
    @(negedge clk);
    check("mrst_req_ready", int'(bus.req_ready), 0);
    check("mrst_flush", int'(bus.flush_tag), 0);
    check("mrst_tag_in", int'(bus.tag_in), 0);
    check("mrst_kernel_size", int'(bus.kernel_size), 1);
    check("mrst_done", int'(bus.done_valid), 0);
    check("mrst_done_tag", int'(bus.done_tag), 0);
    check("mrst_drop", int'(bus.drop_err), 0);
    check("mrst_busy", int'(bus.ctrl_busy), 0);
    tick();
    tick();
    rstn = 1'b1;
    ksm = 1;
    tick();
    set_tag(0, 13);
    set_tag(3, 14);
    bus.req_valid = 4'b1001;
    t = cyc;
    sched(t, 0, 13, 0, l1);
    sched(t + 4, 3, 14, 0, l2);
    tick();
    bus.req_valid[0] = 1'b0;
    wait_to(t + 5);
    bus.req_valid[3] = 1'b0;
    wait_to(l2 + 4);

    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tag_issue_ctrl.md
# tag_issue_ctrl

Scheduler in front of the column tag allocator. It arbitrates tag-load requests from several requesters round-robin and drives the allocator's flush/tag/kernel-size inputs. It checks the allocator's busy response and retries a rejected flush a bounded number of times. It then waits for the tag to shift across the active columns before reporting completion.

## Interface
- NUM_COL, 8: allocator column count; tag width TW = $clog2(NUM_COL)+1.
- NUM_REQ, 4: number of requesters (>=2).
- MAX_RETRY, 3: flush attempts per tag before drop (>=1).
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  load cfg_kernel_size (accepted only in IDLE).
- cfg_kernel_size  in  8  new kernel size.
- req_valid  in  NUM_REQ  per-requester tag request.
- req_tag  in  NUM_REQ*TW  packed tags; requester i at bits [i*TW +: TW].
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
- flush_tag  out  1  allocator flush strobe.
- tag_in  out  TW  tag presented to allocator.
- kernel_size  out  8  registered kernel size to allocator.
- tag_busy  in  1  allocator reject flag, registered in allocator one cycle after flush.
- done_valid  out  1  one-cycle pulse: tag settled.
- done_tag  out  TW  tag of completed/dropped transfer, valid with done_valid or drop_err.
- drop_err  out  1  one-cycle pulse: tag dropped after MAX_RETRY rejects or tag==0.
- ctrl_busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, ISSUE, CHECK, SETTLE.
- Reset: state=IDLE; kernel_size=1; rr pointer=NUM_REQ-1 (req0 highest first); retry_cnt=0; all other outputs 0.
- IDLE, cfg_valid=1: kernel_size<=cfg_kernel_size. No grant that cycle; cfg wins over requests.
- IDLE, cfg_valid=0, any req_valid: req_ready is combinational one-hot. Priority starts at pointer+1 and wraps mod NUM_REQ. On the transfer edge: latch tag, pointer<=granted index, retry_cnt<=0, state<=ISSUE.
- Zero tag: a granted tag of 0 is consumed without issue. drop_err pulses next cycle with done_tag=0; state stays IDLE.
- cfg_valid outside IDLE is ignored; kernel_size never changes mid-transfer.
- ISSUE: flush_tag=1 and tag_in=latched tag for exactly one cycle. retry_cnt++. state<=CHECK.
- CHECK (flush_tag=0): sample tag_busy.
  - 0: load settle counter with ks_eff-1, state<=SETTLE.
  - 1 and retry_cnt<MAX_RETRY: state<=ISSUE (re-flush same tag).
  - 1 and retry_cnt==MAX_RETRY: drop_err pulse and done_tag=tag in the next cycle, state<=IDLE.
- ks_eff = 1 if kernel_size==0; NUM_COL if kernel_size>NUM_COL; else kernel_size.
- SETTLE: decrement counter each cycle. When the counter is 0, done_valid=1 and done_tag=tag for that cycle, state<=IDLE.
- tag_in holds the last issued tag between flushes. It returns to 0 only on reset.
- Counters: settle counter is 8 bits, retry_cnt is $clog2(MAX_RETRY+1) bits; neither wraps.
- Reset asserted mid-transfer: immediate return to reset values. The in-flight tag is lost with no done or drop pulse. Requesters must re-request.

## Timing
- Grant edge at end of cycle T: ISSUE at T+1, CHECK at T+2, SETTLE T+3..T+2+ks_eff, done_valid in cycle T+2+ks_eff.
- Success latency from grant to done = 2+ks_eff cycles. Each retry adds 2 cycles.
- Drop pulse appears in cycle T+1+2*MAX_RETRY.
- Earliest next grant is the cycle after done_valid or drop_err (IDLE), giving back-to-back throughput of one tag per 3+ks_eff cycles.
- req_valid must hold until granted. req_tag must be stable while req_valid=1.
- flush_tag is never high in two consecutive cycles.

## Test plan
- Reset, cfg kernel_size=3, req0 tag=5, tag_busy=0 -> flush_tag pulse one cycle after grant with tag_in=5; done_valid 5 cycles after grant with done_tag=5; kernel_size=3.
- req_valid=4'b1111 held, tag_busy=0 -> grants in order 0,1,2,3,0. After one grant to req2 with only req1 and req3 valid, the next grant is req3.
- tag_busy=1 for first two CHECKs then 0, MAX_RETRY=3 -> three flush pulses spaced 2 cycles apart, then done_valid; no drop_err.
- tag_busy stuck at 1 -> exactly MAX_RETRY=3 flushes, then drop_err with done_tag=issued tag; back to IDLE, next request granted.
- cfg_kernel_size=0 -> SETTLE 1 cycle. cfg_kernel_size=20 -> SETTLE 8 cycles. cfg_valid during SETTLE -> kernel_size unchanged. Tag 0 request -> drop_err, no flush_tag.
- rstn low during SETTLE -> all outputs 0, kernel_size=1, no done pulse; after release, req0 wins first.
